// File: rtl/cic_comp_pkg.sv
// Shared types and helpers for the CIC compensation FIR.
// Optional output saturation is enabled by defining CIC_COMP_SAT_EN.
package cic_comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    function automatic int tap_aw(input int taps);
        return (taps < 2) ? 1 : $clog2(taps);
    endfunction

    // Passthrough: unity gain on tap 0, silence elsewhere.
    function automatic logic [63:0] default_coef(input int idx, input int shift);
        return (idx == 0) ? (64'd1 << shift) : 64'd0;
    endfunction

endpackage

// File: rtl/cic_comp_delay_line.sv
// Circular sample buffer: one write port, one combinational read port.
// Cleared on reset so a restarted stream sees an empty history.
module cic_comp_delay_line
    import cic_comp_pkg::*;
#(
    parameter  int W    = 33,
    parameter  int TAPS = 16,
    localparam int AW   = tap_aw(TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC droop compensation FIR behind the CIC decimator.
// Define CIC_COMP_SAT_EN to clamp the output and expose the sticky ovf flag.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter  int IN_WIDTH   = 32,
    parameter  int IN_OFFSET  = 0,
    parameter  int COEF_WIDTH = 18,
    parameter  int TAPS       = 16,
    parameter  int ACC_WIDTH  = 56,
    parameter  int SHIFT      = 17,
    parameter  int OUT_WIDTH  = 24,
    localparam int AW         = tap_aw(TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  coef_we,
    input  logic [AW-1:0]         coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_wdata,
    output logic                  busy
`ifdef CIC_COMP_SAT_EN
    ,
    output logic                  ovf
`endif
);

    localparam int XW = IN_WIDTH + 1;
    // One spare bit so the unity default 2^SHIFT is representable.
    localparam int CW = COEF_WIDTH + 1;
    localparam int PW = XW + CW;
    localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (SHIFT - 1);

    state_t                         r_state;
    state_t                         w_next;
    logic        [AW-1:0]           r_k;
    logic        [AW-1:0]           r_wr_ptr;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [CW-1:0]           r_coef [TAPS];
    logic        [OUT_WIDTH-1:0]    r_out_data;
    logic                           r_out_valid;

    logic signed [XW-1:0]           w_x;
    logic        [AW-1:0]           w_rd_addr;
    logic signed [XW-1:0]           w_rd_data;
    logic signed [PW-1:0]           w_prod;
    logic signed [ACC_WIDTH-1:0]    w_rnd;
    logic        [OUT_WIDTH-1:0]    w_narrow;
    logic                           w_accept;
    logic                           w_final;

    assign w_x       = $signed({in_data[IN_WIDTH-1], in_data}) - XW'(IN_OFFSET);
    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_rd_addr = r_wr_ptr - r_k;
    assign w_prod    = r_coef[r_k] * w_rd_data;
    assign w_rnd     = r_acc + RND;
    assign w_final   = (r_state == ST_OUT) && !r_out_valid;

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) << (OUT_WIDTH - 1)) - 1;
    localparam logic signed [ACC_WIDTH-1:0] MINV = -(ACC_WIDTH'(1) << (OUT_WIDTH - 1));

    logic signed [ACC_WIDTH-1:0] w_res;
    logic                        w_hi;
    logic                        w_lo;
    logic                        r_ovf;

    assign w_res    = w_rnd >>> SHIFT;
    assign w_hi     = w_res > MAXV;
    assign w_lo     = w_res < MINV;
    assign w_narrow = w_hi ? MAXV[OUT_WIDTH-1:0] :
                      w_lo ? MINV[OUT_WIDTH-1:0] : w_res[OUT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_final && (w_hi || w_lo)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_narrow = OUT_WIDTH'(w_rnd >>> SHIFT);
`endif

    cic_comp_delay_line #(
        .W    (XW),
        .TAPS (TAPS)
    ) u_dl (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_x),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_MAC;
            end
            ST_MAC: begin
                if (r_k == AW'(TAPS - 1)) w_next = ST_OUT;
            end
            ST_OUT: begin
                if (r_out_valid && out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_wr_ptr    <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc <= '0;
                        r_k   <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + ACC_WIDTH'(w_prod);
                    r_k   <= r_k + AW'(1);
                end
                ST_OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_narrow;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_wr_ptr    <= r_wr_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Coefficients change only while idle; the MAC reads them from the next cycle on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= CW'(default_coef(i, SHIFT));
            end
        end else if (coef_we && (r_state == ST_IDLE)) begin
            r_coef[coef_addr] <= {coef_wdata[COEF_WIDTH-1], coef_wdata};
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: default instance plus an IN_OFFSET=1000 twin.
// Build with CIC_COMP_SAT_EN defined to cover the saturating variant.
module tb_cic_comp_fir;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [17:0] coef_wdata;
    logic        in_ready,  in_ready_b;
    logic [23:0] out_data,  out_data_b;
    logic        out_valid, out_valid_b;
    logic        busy,      busy_b;
`ifdef CIC_COMP_SAT_EN
    logic        ovf, ovf_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    longint      m_coef [16];
    longint      m_dl   [2][16];
    int          m_wp;
    bit          m_ovf  [2];
    logic [23:0] q0[$], q1[$];
    bit          qo0[$], qo1[$];

    always #5 clk = ~clk;

    cic_comp_fir u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .busy(busy)
`ifdef CIC_COMP_SAT_EN
        , .ovf(ovf)
`endif
    );

    cic_comp_fir #(.IN_OFFSET(1000)) u_off (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .busy(busy_b)
`ifdef CIC_COMP_SAT_EN
        , .ovf(ovf_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_out(input int inst, output bit clip);
        longint acc = 0;
        longint r;
        for (int k = 0; k < 16; k++) acc += m_coef[k] * m_dl[inst][(m_wp - k) & 15];
        r = (acc + 64'sd65536) >>> 17;
        clip = 1'b0;
`ifdef CIC_COMP_SAT_EN
        if (r > 8388607) begin r = 8388607; clip = 1'b1; end
        else if (r < -8388608) begin r = -8388608; clip = 1'b1; end
`endif
        return r[23:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_coef[k]  = (k == 0) ? 131072 : 0;
            m_dl[0][k] = 0;
            m_dl[1][k] = 0;
        end
        m_wp = 0;
        m_ovf[0] = 1'b0;
        m_ovf[1] = 1'b0;
        q0.delete(); q1.delete(); qo0.delete(); qo1.delete();
    endtask

    task automatic model_accept(input logic [31:0] v);
        longint x = longint'($signed(v));
        bit c0, c1;
        m_dl[0][m_wp] = x;
        m_dl[1][m_wp] = x - 1000;
        q0.push_back(model_out(0, c0));
        q1.push_back(model_out(1, c1));
        if (c0) m_ovf[0] = 1'b1;
        if (c1) m_ovf[1] = 1'b1;
        qo0.push_back(m_ovf[0]);
        qo1.push_back(m_ovf[1]);
        m_wp = (m_wp + 1) & 15;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q0.size() == 0) begin
                check("out_unexpected", q0.size(), 1);
            end else begin
                check("out", out_data, q0.pop_front());
                check("out_off", out_data_b, q1.pop_front());
                check("out_off_vld", out_valid_b, 1);
`ifdef CIC_COMP_SAT_EN
                check("ovf", ovf, qo0.pop_front());
                check("ovf_off", ovf_b, qo1.pop_front());
`else
                void'(qo0.pop_front());
                void'(qo1.pop_front());
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v);
        int n = 0;
        bit ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready && in_ready_b;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (ok) model_accept(v);
        else check("accept_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        bit pend;
        do begin
            @(negedge clk);
            n++;
            pend = busy || busy_b || (q0.size() != 0);
        end while (pend && n < 300);
        check("idle_timeout", pend, 0);
        tick();
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = 4'(a);
        coef_wdata = 18'(v);
        tick();
        coef_we = 1'b0;
        m_coef[a] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
`ifdef CIC_COMP_SAT_EN
        check("rst_ovf", ovf, 0);
`endif
        tick();

        // passthrough, latency and offset removal
        send(100);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            if (!out_valid) n++;
        end
        check("latency", n, 17);
        wait_idle();
        send(-5);
        wait_idle();
        send(1100);
        wait_idle();

        // 16-tap moving average
        do_reset();
        for (int i = 0; i < 16; i++) wr_coef(i, 8192);
        for (int i = 0; i < 18; i++) begin
            send(1600);
            wait_idle();
        end

        // round half up with c0 = 0.5
        do_reset();
        wr_coef(0, 65536);
        send(3);  wait_idle();
        send(-3); wait_idle();
        send(1);  wait_idle();

        // backpressure: output held, ignored coef write
        out_ready = 1'b0;
        send(7);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_hold", out_data, q0[0]);
            check("bp_in_ready", in_ready, 0);
            tick();
            coef_we    = (i == 1);
            coef_addr  = '0;
            coef_wdata = '0;
        end
        coef_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle", busy, 0);
        check("bp_in_ready_back", in_ready, 1);
        tick();
        send(7);
        wait_idle();

        // overflow of the narrowed result
        do_reset();
        send(32'h4000_0000);
        wait_idle();
`ifdef CIC_COMP_SAT_EN
        check("ovf_sticky", ovf, 1);
`endif

        // reset while the MAC is running
        do_reset();
`ifdef CIC_COMP_SAT_EN
        check("ovf_cleared", ovf, 0);
`endif
        for (int i = 0; i < 16; i++) wr_coef(i, 8192);
        send(1600);
        wait_idle();
        send(1600);
        repeat (5) tick();
        do_reset();
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        tick();
        for (int i = 0; i < 16; i++) wr_coef(i, 8192);
        send(1600);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
